// File: rtl/riscv_pkg.sv
// Shared definitions for the front end: NOP encoding, default reset PC and
// the fetch FSM state type.
package riscv_pkg;

    localparam int          XLEN             = 32;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_HOLD = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/if_skid_buffer.sv
// One-entry {pc, instr} holding register for a fetch response that arrived
// while decode was stalled.
module if_skid_buffer
    import riscv_pkg::*;
#(
    parameter int XLEN = riscv_pkg::XLEN
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            load_i,
    input  logic            clear_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [31:0]     instr_i,
    output logic            full_o,
    output logic [XLEN-1:0] pc_o,
    output logic [31:0]     instr_o
);

    logic            full_q,  full_d;
    logic [XLEN-1:0] pc_q,    pc_d;
    logic [31:0]     instr_q, instr_d;

    always_comb begin
        full_d  = full_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        if (clear_i) begin
            full_d = 1'b0;
        end else if (load_i) begin
            full_d  = 1'b1;
            pc_d    = pc_i;
            instr_d = instr_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            full_q  <= 1'b0;
            pc_q    <= '0;
            instr_q <= NOP_INSTR;
        end else begin
            full_q  <= full_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign full_o  = full_q;
    assign pc_o    = pc_q;
    assign instr_o = instr_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, single-outstanding imem handshake, IF/ID register,
// stall/flush handling and a skid entry for responses caught by a stall.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = riscv_pkg::DEFAULT_RESET_PC,
    parameter int          XLEN     = riscv_pkg::XLEN
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] branch_target_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic [31:0]     imem_rdata_i,
    input  logic            imem_valid_i,
    output logic            if_id_valid_o,
    output logic [XLEN-1:0] if_id_pc_o,
    output logic [31:0]     if_id_instr_o
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            if_id_valid_q, if_id_valid_d;
    logic [XLEN-1:0] if_id_pc_q, if_id_pc_d;
    logic [31:0]     if_id_instr_q, if_id_instr_d;

    logic            skid_load, skid_clear, skid_full;
    logic [XLEN-1:0] skid_pc;
    logic [31:0]     skid_instr;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] pc_next;

    assign target  = branch_target_i & ~{{(XLEN-2){1'b0}}, 2'b11};
    assign pc_next = pc_q + XLEN'(4);

    if_skid_buffer #(.XLEN(XLEN)) u_skid (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (skid_load),
        .clear_i (skid_clear),
        .pc_i    (pc_q),
        .instr_i (imem_rdata_i),
        .full_o  (skid_full),
        .pc_o    (skid_pc),
        .instr_o (skid_instr)
    );

    always_comb begin
        // NOTE: every signal gets its hold value first, so no path through the
        // case can leave one unassigned and infer a latch.
        state_d       = state_q;
        pc_d          = pc_q;
        if_id_valid_d = if_id_valid_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_instr_d = if_id_instr_q;
        skid_load     = 1'b0;
        skid_clear    = 1'b0;

        unique case (state_q)
            ST_REQ: begin
                if (flush_i) begin
                    if_id_valid_d = 1'b0;
                    if_id_instr_d = NOP_INSTR;
                    skid_clear    = 1'b1;
                    pc_d          = target;
                    // A same-cycle response closes the request; otherwise it is still in flight.
                    state_d       = imem_valid_i ? ST_REQ : ST_DROP;
                end else if (imem_valid_i) begin
                    pc_d = pc_next;
                    if (!if_id_valid_q || !stall_i) begin
                        if_id_valid_d = 1'b1;
                        if_id_pc_d    = pc_q;
                        if_id_instr_d = imem_rdata_i;
                    end else begin
                        skid_load = 1'b1;
                        state_d   = ST_HOLD;
                    end
                end else if (!stall_i) begin
                    if_id_valid_d = 1'b0;
                    if_id_instr_d = NOP_INSTR;
                end
            end
            ST_HOLD: begin
                if (flush_i) begin
                    if_id_valid_d = 1'b0;
                    if_id_instr_d = NOP_INSTR;
                    skid_clear    = 1'b1;
                    pc_d          = target;
                    state_d       = ST_REQ;
                end else if (!stall_i) begin
                    if_id_valid_d = 1'b1;
                    if_id_pc_d    = skid_pc;
                    if_id_instr_d = skid_instr;
                    skid_clear    = 1'b1;
                    state_d       = ST_REQ;
                end
            end
            ST_DROP: begin
                if (flush_i) begin
                    if_id_valid_d = 1'b0;
                    if_id_instr_d = NOP_INSTR;
                    pc_d          = target;
                end
                if (imem_valid_i) begin
                    state_d = ST_REQ;
                end
            end
            default: begin
                state_d = ST_REQ;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst_i) begin
            state_q       <= ST_REQ;
            pc_q          <= XLEN'(RESET_PC);
            if_id_valid_q <= 1'b0;
            if_id_pc_q    <= '0;
            if_id_instr_q <= NOP_INSTR;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            if_id_valid_q <= if_id_valid_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_instr_q <= if_id_instr_d;
        end
    end

    assign imem_req_o    = (state_q == ST_REQ) && !rst_i;
    assign imem_addr_o   = pc_q;
    assign if_id_valid_o = if_id_valid_q;
    assign if_id_pc_o    = if_id_pc_q;
    assign if_id_instr_o = if_id_instr_q;

    // No request is outstanding in HOLD, so a response there is a memory protocol error.
    a_no_valid_in_hold: assert property (
        @(posedge clk_i) disable iff (rst_i) !(state_q == ST_HOLD && imem_valid_i)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage plus hand sequences for
// reset-in-HOLD and PC wrap-around.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;

    logic        stall, flush, vld;
    logic [31:0] tgt, rdata;
    logic        req;
    logic [31:0] addr;
    logic        ifv;
    logic [31:0] ifpc, ifinstr;

    logic        b_vld;
    logic [31:0] b_rdata;
    logic        b_req;
    logic [31:0] b_addr;
    logic        b_ifv;
    logic [31:0] b_ifpc, b_ifinstr;

    int checks   = 0;
    int failures = 0;

    fetch_stage dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .stall_i         (stall),
        .flush_i         (flush),
        .branch_target_i (tgt),
        .imem_req_o      (req),
        .imem_addr_o     (addr),
        .imem_rdata_i    (rdata),
        .imem_valid_i    (vld),
        .if_id_valid_o   (ifv),
        .if_id_pc_o      (ifpc),
        .if_id_instr_o   (ifinstr)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk_i           (clk),
        .rst_i           (rst),
        .stall_i         (1'b0),
        .flush_i         (1'b0),
        .branch_target_i (32'h0),
        .imem_req_o      (b_req),
        .imem_addr_o     (b_addr),
        .imem_rdata_i    (b_rdata),
        .imem_valid_i    (b_vld),
        .if_id_valid_o   (b_ifv),
        .if_id_pc_o      (b_ifpc),
        .if_id_instr_o   (b_ifinstr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        stall;
        logic        flush;
        logic [31:0] tgt;
        logic        vld;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_v;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
    } vec_t;

    vec_t vecs[22];

    function automatic vec_t mk(input logic s, input logic f, input logic [31:0] t,
                                input logic v, input logic [31:0] d,
                                input logic er, input logic [31:0] ea, input logic ev,
                                input logic [31:0] ep, input logic [31:0] ei);
        vec_t r;
        r.stall = s; r.flush = f; r.tgt = t; r.vld = v; r.rdata = d;
        r.e_req = er; r.e_addr = ea; r.e_v = ev; r.e_pc = ep; r.e_instr = ei;
        return r;
    endfunction

    function automatic logic [31:0] dat(input logic [31:0] a);
        return 32'hA000_0000 | a;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    initial begin
        //          stall flush tgt        vld data          req addr       v  if_pc      instr
        vecs[0]  = mk(0, 0, 32'h0,   1, dat(32'h0),   1, 32'h0,   0, 32'h0,   NOP);
        vecs[1]  = mk(0, 0, 32'h0,   1, dat(32'h4),   1, 32'h4,   1, 32'h0,   dat(32'h0));
        vecs[2]  = mk(1, 0, 32'h0,   1, dat(32'h8),   1, 32'h8,   1, 32'h4,   dat(32'h4));
        vecs[3]  = mk(1, 0, 32'h0,   0, 32'h0,        0, 32'hC,   1, 32'h4,   dat(32'h4));
        vecs[4]  = mk(1, 0, 32'h0,   0, 32'h0,        0, 32'hC,   1, 32'h4,   dat(32'h4));
        vecs[5]  = mk(0, 0, 32'h0,   0, 32'h0,        0, 32'hC,   1, 32'h4,   dat(32'h4));
        vecs[6]  = mk(0, 0, 32'h0,   1, dat(32'hC),   1, 32'hC,   1, 32'h8,   dat(32'h8));
        vecs[7]  = mk(0, 0, 32'h0,   0, 32'h0,        1, 32'h10,  1, 32'hC,   dat(32'hC));
        vecs[8]  = mk(0, 1, 32'h100, 0, 32'h0,        1, 32'h10,  0, 32'hC,   NOP);
        vecs[9]  = mk(0, 0, 32'h0,   1, dat(32'h10),  0, 32'h100, 0, 32'hC,   NOP);
        vecs[10] = mk(0, 0, 32'h0,   1, dat(32'h100), 1, 32'h100, 0, 32'hC,   NOP);
        vecs[11] = mk(0, 1, 32'h203, 1, dat(32'h104), 1, 32'h104, 1, 32'h100, dat(32'h100));
        vecs[12] = mk(0, 0, 32'h0,   1, dat(32'h200), 1, 32'h200, 0, 32'h100, NOP);
        vecs[13] = mk(1, 0, 32'h0,   0, 32'h0,        1, 32'h204, 1, 32'h200, dat(32'h200));
        vecs[14] = mk(1, 1, 32'h300, 0, 32'h0,        1, 32'h204, 1, 32'h200, dat(32'h200));
        vecs[15] = mk(0, 1, 32'h400, 0, 32'h0,        0, 32'h300, 0, 32'h200, NOP);
        vecs[16] = mk(0, 0, 32'h0,   1, 32'hDEAD_BEEF,0, 32'h400, 0, 32'h200, NOP);
        vecs[17] = mk(1, 0, 32'h0,   1, dat(32'h400), 1, 32'h400, 0, 32'h200, NOP);
        vecs[18] = mk(1, 0, 32'h0,   1, dat(32'h404), 1, 32'h404, 1, 32'h400, dat(32'h400));
        vecs[19] = mk(1, 1, 32'h500, 0, 32'h0,        0, 32'h408, 1, 32'h400, dat(32'h400));
        vecs[20] = mk(0, 0, 32'h0,   1, dat(32'h500), 1, 32'h500, 0, 32'h400, NOP);
        vecs[21] = mk(1, 0, 32'h0,   1, dat(32'h504), 1, 32'h504, 1, 32'h500, dat(32'h500));

        rst = 1'b1; stall = 0; flush = 0; vld = 0; tgt = 0; rdata = 0;
        b_vld = 0; b_rdata = 0;
        #12;
        check("reset_req",   {31'b0, req}, 32'h0);
        check("reset_addr",  addr,         32'h0);
        check("reset_ifv",   {31'b0, ifv}, 32'h0);
        check("reset_ifpc",  ifpc,         32'h0);
        check("reset_instr", ifinstr,      NOP);
        check("reset_wrap_addr", b_addr,   32'hFFFF_FFF8);

        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 22; i++) begin
            stall = vecs[i].stall; flush = vecs[i].flush; tgt = vecs[i].tgt;
            vld = vecs[i].vld; rdata = vecs[i].rdata;
            #1;
            check($sformatf("v%0d_req", i),   {31'b0, req}, {31'b0, vecs[i].e_req});
            check($sformatf("v%0d_addr", i),  addr,         vecs[i].e_addr);
            check($sformatf("v%0d_ifv", i),   {31'b0, ifv}, {31'b0, vecs[i].e_v});
            check($sformatf("v%0d_ifpc", i),  ifpc,         vecs[i].e_pc);
            check($sformatf("v%0d_instr", i), ifinstr,      vecs[i].e_instr);
            @(negedge clk);
        end

        // Reset while HOLD has a full skid entry (loaded by the last vector).
        stall = 1; flush = 0; vld = 0; rdata = 0;
        #1;
        check("hold_req",  {31'b0, req}, 32'h0);
        check("hold_full", {31'b0, dut.u_skid.full_o}, 32'h1);
        #1 rst = 1'b1;
        #1;
        check("midrst_ifv",   {31'b0, ifv}, 32'h0);
        check("midrst_req",   {31'b0, req}, 32'h0);
        check("midrst_full",  {31'b0, dut.u_skid.full_o}, 32'h0);
        check("midrst_instr", ifinstr, NOP);
        check("midrst_addr",  addr,    32'h0);
        @(negedge clk);
        rst = 1'b0; stall = 0; vld = 1; rdata = dat(32'h0);
        #1;
        check("postrst_req",  {31'b0, req}, 32'h1);
        check("postrst_addr", addr,         32'h0);
        @(negedge clk);
        vld = 0;
        #1;
        check("postrst_ifv",   {31'b0, ifv}, 32'h1);
        check("postrst_ifpc",  ifpc,         32'h0);
        check("postrst_instr", ifinstr,      dat(32'h0));
        check("postrst_addr2", addr,         32'h4);

        // PC wrap-around on the second instance, zero-wait responses.
        @(negedge clk);
        b_vld = 1; b_rdata = 32'h1111_0001;
        #1 check("wrap_addr0", b_addr, 32'hFFFF_FFF8);
        @(negedge clk);
        b_rdata = 32'h1111_0002;
        #1 check("wrap_addr1", b_addr, 32'hFFFF_FFFC);
        check("wrap_ifpc0",  b_ifpc,    32'hFFFF_FFF8);
        check("wrap_instr0", b_ifinstr, 32'h1111_0001);
        @(negedge clk);
        b_rdata = 32'h1111_0003;
        #1 check("wrap_addr2", b_addr, 32'h0000_0000);
        check("wrap_ifpc1",  b_ifpc,    32'hFFFF_FFFC);
        check("wrap_ifv1",   {31'b0, b_ifv}, 32'h1);
        @(negedge clk);
        b_vld = 0;
        #1 check("wrap_ifpc2", b_ifpc,    32'h0000_0000);
        check("wrap_instr2", b_ifinstr, 32'h1111_0003);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
